// File: rtl/id_ex_pipe.sv
// id_ex_pipe: architectural register file, ID/EX register and a WB_DEPTH-stage
// destination delay line that scoreboards in-flight writers for RAW hazards.
// Optional feature macro: ID_EX_BYPASS_EN (write-through read of wb_data; the
// write stage is then excluded from the hazard check).
module id_ex_pipe #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned CTRL_W     = 16,
    parameter int unsigned WB_DEPTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] in_rs_sel,
    input  logic [REG_ADDR_W-1:0] in_rt_sel,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_wrt,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic [DATA_W-1:0]     in_pc,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_rs_data,
    output logic [DATA_W-1:0]     out_rt_data,
    output logic [DATA_W-1:0]     out_imm,
    output logic [DATA_W-1:0]     out_pc,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_wrt,
    output logic                  hazard,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_sel
);

    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
`ifdef ID_EX_BYPASS_EN
    // The write stage is forwarded, so it never needs to block a reader.
    localparam int unsigned HAZ_DEPTH = WB_DEPTH - 1;
`else
    localparam int unsigned HAZ_DEPTH = WB_DEPTH;
`endif

    logic [DATA_W-1:0]     rf [NUM_REGS];
    logic [WB_DEPTH-1:0]   stg_valid;
    logic [WB_DEPTH-1:0]   stg_wrt;
    logic [REG_ADDR_W-1:0] stg_rd [WB_DEPTH];
    logic [DATA_W-1:0]     rs_rd;
    logic [DATA_W-1:0]     rt_rd;
    logic                  raw_hit;
    logic                  s1_hold;
    logic                  s1_load;

    // Stage 1 is the ID/EX register; the last stage drives the write port.
    assign out_valid   = stg_valid[0];
    assign out_reg_wrt = stg_wrt[0];
    assign out_rd      = stg_rd[0];
    assign wb_en       = stg_valid[WB_DEPTH-1] & stg_wrt[WB_DEPTH-1];
    assign wb_sel      = stg_rd[WB_DEPTH-1];

    // Scoreboard: any tracked in-flight writer matching either source select.
    always_comb begin
        raw_hit = 1'b0;
        for (int k = 0; k < int'(HAZ_DEPTH); k++) begin
            if (stg_valid[k] && stg_wrt[k] &&
                (stg_rd[k] == in_rs_sel || stg_rd[k] == in_rt_sel)) begin
                raw_hit = 1'b1;
            end
        end
    end

    assign hazard   = in_valid & raw_hit;
    assign in_ready = ~rst & (flush | (~stall & ~hazard));

    // Flush overrides stall; a held S1 sends a bubble down to S2.
    assign s1_hold = ~flush & stall;
    assign s1_load = ~flush & ~stall & ~hazard & in_valid;

    // Register-file read ports, optionally write-through from the WB port.
    always_comb begin
        rs_rd = rf[in_rs_sel];
        rt_rd = rf[in_rt_sel];
`ifdef ID_EX_BYPASS_EN
        if (wb_en && wb_sel == in_rs_sel) begin
            rs_rd = wb_data;
        end
        if (wb_en && wb_sel == in_rt_sel) begin
            rt_rd = wb_data;
        end
`endif
    end

    // ID/EX register and destination delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid <= '0;
            stg_wrt   <= '0;
            for (int k = 0; k < int'(WB_DEPTH); k++) begin
                stg_rd[k] <= '0;
            end
            out_rs_data <= '0;
            out_rt_data <= '0;
            out_imm     <= '0;
            out_pc      <= '0;
            out_ctrl    <= '0;
        end else begin
            for (int k = 1; k < int'(WB_DEPTH); k++) begin
                if (k == 1 && s1_hold) begin
                    stg_valid[k] <= 1'b0;
                    stg_wrt[k]   <= 1'b0;
                    stg_rd[k]    <= '0;
                end else begin
                    stg_valid[k] <= stg_valid[k-1];
                    stg_wrt[k]   <= stg_wrt[k-1];
                    stg_rd[k]    <= stg_rd[k-1];
                end
            end
            if (s1_load) begin
                stg_valid[0] <= 1'b1;
                stg_wrt[0]   <= in_reg_wrt;
                stg_rd[0]    <= in_rd;
                out_rs_data  <= rs_rd;
                out_rt_data  <= rt_rd;
                out_imm      <= in_imm;
                out_pc       <= in_pc;
                out_ctrl     <= in_ctrl;
            end else if (!s1_hold) begin
                stg_valid[0] <= 1'b0;
                stg_wrt[0]   <= 1'b0;
                stg_rd[0]    <= '0;
                out_rs_data  <= '0;
                out_rt_data  <= '0;
                out_imm      <= '0;
                out_pc       <= '0;
                out_ctrl     <= '0;
            end
        end
    end

    // Register file write port; contents survive reset, no write on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && wb_en) begin
            rf[wb_sel] <= wb_data;
        end
    end

endmodule
